// File: rtl/minisrc_datapath.sv
// MiniSRC 32-bit register-transfer datapath: PC, 16x32 register file, RA/RB operands,
// 64-bit ALU feeding RZH/RZL, RAS and RWB, all sequenced by an external control unit.
module minisrc_datapath (
   input  logic        iClk,
   input  logic        nRst,
   input  logic [31:0] iMemData,
   output logic [31:0] oMemAddr,
   output logic [31:0] oMemData,
   input  logic        iPC_nRst,
   input  logic        iPC_en,
   input  logic        iPC_jmp,
   input  logic        iPC_loadRA,
   input  logic        iPC_loadImm,
   input  logic        iRF_Write,
   input  logic [3:0]  iRF_AddrA,
   input  logic [3:0]  iRF_AddrB,
   input  logic [3:0]  iRF_AddrC,
   input  logic        iRWB_en,
   input  logic [3:0]  iALU_Ctrl,
   input  logic        iRA_en,
   input  logic        iRB_en,
   input  logic        iRZH_en,
   input  logic        iRZL_en,
   input  logic        iRAS_en,
   output logic        oJ_zero,
   output logic        oJ_nZero,
   output logic        oJ_pos,
   output logic        oJ_neg,
   output logic        oALU_neg,
   output logic        oALU_zero,
   input  logic        iMUX_BIS,
   input  logic        iMUX_RZHS,
   input  logic        iMUX_WBM,
   input  logic        iMUX_WBP,
   input  logic        iMUX_MAP,
   input  logic        iMUX_ASS,
   input  logic [31:0] iImm32
);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_SHR  = 4'd4,
      ALU_SHRA = 4'd5,
      ALU_SHL  = 4'd6,
      ALU_ROR  = 4'd7,
      ALU_ROL  = 4'd8,
      ALU_MUL  = 4'd9,
      ALU_DIV  = 4'd10,
      ALU_NEG  = 4'd11,
      ALU_NOT  = 4'd12
   } alu_op_e;

   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [16];
   logic [31:0] ra_q, rb_q, rzh_q, rzl_q, ras_q, rwb_q;

   logic [31:0] rf_a, rf_b;
   logic [31:0] rb_d, res, wb_d;
   logic [31:0] alu_lo, alu_hi;
   logic [4:0]  shamt;
   logic signed [63:0] ra_sx, rb_sx, product;
   logic signed [31:0] ra_s, rb_s;

   assign rf_a = rf_q[iRF_AddrA];
   assign rf_b = rf_q[iRF_AddrB];

   assign shamt = rb_q[4:0];
   assign ra_s  = ra_q;
   assign rb_s  = rb_q;
   assign ra_sx = {{32{ra_q[31]}}, ra_q};
   assign rb_sx = {{32{rb_q[31]}}, rb_q};
   assign product = ra_sx * rb_sx;

   always_comb begin
      alu_lo = rb_q;
      alu_hi = '0;
      case (iALU_Ctrl)
         ALU_ADD:  alu_lo = ra_q + rb_q;
         ALU_SUB:  alu_lo = ra_q - rb_q;
         ALU_AND:  alu_lo = ra_q & rb_q;
         ALU_OR:   alu_lo = ra_q | rb_q;
         ALU_SHR:  alu_lo = ra_q >> shamt;
         ALU_SHRA: alu_lo = ra_s >>> shamt;
         ALU_SHL:  alu_lo = ra_q << shamt;
         // a 6-bit complement amount of 32 shifts out fully, so amount 0 is a plain copy
         ALU_ROR:  alu_lo = (ra_q >> shamt) | (ra_q << (6'd32 - {1'b0, shamt}));
         ALU_ROL:  alu_lo = (ra_q << shamt) | (ra_q >> (6'd32 - {1'b0, shamt}));
         ALU_MUL: begin
            alu_lo = product[31:0];
            alu_hi = product[63:32];
         end
         ALU_DIV: begin
            if (rb_q == '0) begin
               alu_lo = '1;
               alu_hi = ra_q;
            end else begin
               alu_lo = ra_s / rb_s;
               alu_hi = ra_s % rb_s;
            end
         end
         ALU_NEG:  alu_lo = ~rb_q + 32'd1;
         ALU_NOT:  alu_lo = ~rb_q;
         default:  alu_lo = rb_q;
      endcase
   end

   assign oALU_zero = (alu_lo == '0);
   assign oALU_neg  = alu_lo[31];

   assign oJ_zero  = (ra_q == '0);
   assign oJ_nZero = ~oJ_zero;
   assign oJ_neg   = ra_q[31];
   assign oJ_pos   = ~ra_q[31];

   assign rb_d = iMUX_BIS ? iImm32 : rf_b;
   assign res  = iMUX_RZHS ? rzh_q : rzl_q;

   always_comb begin
      if (iMUX_WBM)      wb_d = iMemData;
      else if (iMUX_WBP) wb_d = pc_q;
      else if (iMUX_ASS) wb_d = ras_q;
      else               wb_d = res;
   end

   always_comb begin
      if (!iPC_nRst)                     pc_d = '0;
      else if (!iPC_en)                  pc_d = pc_q;
      else if (iPC_jmp && iPC_loadRA)    pc_d = ra_q;
      else if (iPC_jmp && iPC_loadImm)   pc_d = pc_q + iImm32;
      else                               pc_d = pc_q + 32'd1;
   end

   assign oMemAddr = iMUX_MAP ? pc_q : res;
   assign oMemData = rf_b;

   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         pc_q  <= '0;
         ra_q  <= '0;
         rb_q  <= '0;
         rzh_q <= '0;
         rzl_q <= '0;
         ras_q <= '0;
         rwb_q <= '0;
         for (int unsigned i = 0; i < 16; i++) rf_q[i] <= '0;
      end else begin
         pc_q <= pc_d;
         if (iRA_en)    ra_q  <= rf_a;
         if (iRB_en)    rb_q  <= rb_d;
         if (iRZH_en)   rzh_q <= alu_hi;
         if (iRZL_en)   rzl_q <= alu_lo;
         if (iRAS_en)   ras_q <= res;
         if (iRWB_en)   rwb_q <= wb_d;
         if (iRF_Write) rf_q[iRF_AddrC] <= rwb_q;
      end
   end

endmodule

// File: tb/tb_minisrc_datapath.sv
// Directed-vector bench for the MiniSRC datapath; results observed through oMemAddr,
// oMemData and the flag outputs only.
module tb_minisrc_datapath;

   logic        iClk = 1'b0;
   logic        nRst;
   logic [31:0] iMemData;
   logic [31:0] oMemAddr, oMemData;
   logic        iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm;
   logic        iRF_Write;
   logic [3:0]  iRF_AddrA, iRF_AddrB, iRF_AddrC;
   logic        iRWB_en;
   logic [3:0]  iALU_Ctrl;
   logic        iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en;
   logic        oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_neg, oALU_zero;
   logic        iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS;
   logic [31:0] iImm32;

   int checks = 0;
   int passes = 0;

   logic [3:0]  op_t  [12];
   logic [31:0] rb_t  [12];
   logic [31:0] exp_t [12];

   minisrc_datapath dut (
      .iClk(iClk), .nRst(nRst), .iMemData(iMemData), .oMemAddr(oMemAddr), .oMemData(oMemData),
      .iPC_nRst(iPC_nRst), .iPC_en(iPC_en), .iPC_jmp(iPC_jmp), .iPC_loadRA(iPC_loadRA),
      .iPC_loadImm(iPC_loadImm), .iRF_Write(iRF_Write), .iRF_AddrA(iRF_AddrA),
      .iRF_AddrB(iRF_AddrB), .iRF_AddrC(iRF_AddrC), .iRWB_en(iRWB_en), .iALU_Ctrl(iALU_Ctrl),
      .iRA_en(iRA_en), .iRB_en(iRB_en), .iRZH_en(iRZH_en), .iRZL_en(iRZL_en), .iRAS_en(iRAS_en),
      .oJ_zero(oJ_zero), .oJ_nZero(oJ_nZero), .oJ_pos(oJ_pos), .oJ_neg(oJ_neg),
      .oALU_neg(oALU_neg), .oALU_zero(oALU_zero), .iMUX_BIS(iMUX_BIS), .iMUX_RZHS(iMUX_RZHS),
      .iMUX_WBM(iMUX_WBM), .iMUX_WBP(iMUX_WBP), .iMUX_MAP(iMUX_MAP), .iMUX_ASS(iMUX_ASS),
      .iImm32(iImm32)
   );

   always #5 iClk = ~iClk;

   task automatic idle();
      iMemData = '0; iPC_nRst = 1'b1; iPC_en = 1'b0; iPC_jmp = 1'b0; iPC_loadRA = 1'b0;
      iPC_loadImm = 1'b0; iRF_Write = 1'b0; iRF_AddrA = '0; iRF_AddrB = '0; iRF_AddrC = '0;
      iRWB_en = 1'b0; iALU_Ctrl = '0; iRA_en = 1'b0; iRB_en = 1'b0; iRZH_en = 1'b0;
      iRZL_en = 1'b0; iRAS_en = 1'b0; iMUX_BIS = 1'b0; iMUX_RZHS = 1'b0; iMUX_WBM = 1'b0;
      iMUX_WBP = 1'b0; iMUX_MAP = 1'b0; iMUX_ASS = 1'b0; iImm32 = '0;
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic load_reg(input logic [3:0] r, input logic [31:0] v);
      iMemData = v; iMUX_WBM = 1'b1; iRWB_en = 1'b1;
      tick();
      iMUX_WBM = 1'b0; iRWB_en = 1'b0; iRF_AddrC = r; iRF_Write = 1'b1;
      tick();
      iRF_Write = 1'b0;
   endtask

   task automatic load_ra(input logic [3:0] r);
      iRF_AddrA = r; iRA_en = 1'b1;
      tick();
      iRA_en = 1'b0;
   endtask

   task automatic load_rb_imm(input logic [31:0] v);
      iMUX_BIS = 1'b1; iImm32 = v; iRB_en = 1'b1;
      tick();
      iMUX_BIS = 1'b0; iRB_en = 1'b0;
   endtask

   task automatic exec(input logic [3:0] op);
      iALU_Ctrl = op; iRZH_en = 1'b1; iRZL_en = 1'b1;
      tick();
      iRZH_en = 1'b0; iRZL_en = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      nRst = 1'b0;
      #3;
      checks++;
      if (oMemAddr !== 32'h0 || oMemData !== 32'h0) $display("FAIL reset_bus: addr=%h data=%h required 0/0", oMemAddr, oMemData);
      else passes++;
      checks++;
      if ({oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_zero, oALU_neg} !== 6'b101010)
         $display("FAIL reset_flags: got %b required 101010", {oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_zero, oALU_neg});
      else passes++;
      #9 nRst = 1'b1;
   endtask

   task automatic test_regload();
      load_reg(4'd3, 32'h22);
      load_reg(4'd7, 32'h24);
      iMemData = 32'h28; iMUX_WBM = 1'b1; iRWB_en = 1'b1;
      tick();
      iMUX_WBM = 1'b0; iRWB_en = 1'b0; iRF_AddrC = 4'd4; iRF_Write = 1'b1; iRF_AddrB = 4'd4;
      #1;
      checks++;
      if (oMemData !== 32'h0) $display("FAIL rf_read_during_write: got %h required %h", oMemData, 32'h0);
      else passes++;
      tick();
      iRF_Write = 1'b0;
      checks++;
      if (oMemData !== 32'h28) $display("FAIL rf_R4: got %h required %h", oMemData, 32'h28);
      else passes++;
      iRF_AddrB = 4'd3; #1;
      checks++;
      if (oMemData !== 32'h22) $display("FAIL rf_R3: got %h required %h", oMemData, 32'h22);
      else passes++;
      iRF_AddrB = 4'd7; #1;
      checks++;
      if (oMemData !== 32'h24) $display("FAIL rf_R7: got %h required %h", oMemData, 32'h24);
      else passes++;
   endtask

   task automatic test_sub();
      iMUX_MAP = 1'b1; iPC_en = 1'b1; iPC_jmp = 1'b1; #1;
      checks++;
      if (oMemAddr !== 32'h0) $display("FAIL fetch_addr: got %h required %h", oMemAddr, 32'h0);
      else passes++;
      tick();
      checks++;
      if (oMemAddr !== 32'h1) $display("FAIL pc_inc: got %h required %h", oMemAddr, 32'h1);
      else passes++;
      iPC_en = 1'b0; iPC_jmp = 1'b0; iMUX_MAP = 1'b0;
      iRF_AddrA = 4'd3; iRF_AddrB = 4'd7; iRA_en = 1'b1; iRB_en = 1'b1;
      tick();
      iRA_en = 1'b0; iRB_en = 1'b0; iALU_Ctrl = 4'd1; #1;
      checks++;
      if (oALU_neg !== 1'b1 || oALU_zero !== 1'b0) $display("FAIL sub_flags: neg=%b zero=%b required 1/0", oALU_neg, oALU_zero);
      else passes++;
      exec(4'd1);
      iMUX_RZHS = 1'b1; #1;
      checks++;
      if (oMemAddr !== 32'h0) $display("FAIL sub_rzh: got %h required %h", oMemAddr, 32'h0);
      else passes++;
      iMUX_RZHS = 1'b0; #1;
      checks++;
      if (oMemAddr !== 32'hFFFFFFFE) $display("FAIL sub_rzl: got %h required %h", oMemAddr, 32'hFFFFFFFE);
      else passes++;
      iRWB_en = 1'b1;
      tick();
      iRWB_en = 1'b0; iRF_AddrB = 4'd4; #1;
      checks++;
      if (oMemData !== 32'h28) $display("FAIL sub_latency: got %h required %h", oMemData, 32'h28);
      else passes++;
      iRF_AddrC = 4'd4; iRF_Write = 1'b1;
      tick();
      iRF_Write = 1'b0;
      checks++;
      if (oMemData !== 32'hFFFFFFFE) $display("FAIL sub_R4: got %h required %h", oMemData, 32'hFFFFFFFE);
      else passes++;
   endtask

   task automatic test_mul_div();
      load_reg(4'd1, 32'd5);
      load_ra(4'd1);
      load_rb_imm(32'hFFFFFFFD);
      exec(4'd9);
      #1;
      checks++;
      if (oMemAddr !== 32'hFFFFFFF1) $display("FAIL mul_lo: got %h required %h", oMemAddr, 32'hFFFFFFF1);
      else passes++;
      iMUX_RZHS = 1'b1; #1;
      checks++;
      if (oMemAddr !== 32'hFFFFFFFF) $display("FAIL mul_hi: got %h required %h", oMemAddr, 32'hFFFFFFFF);
      else passes++;
      iRAS_en = 1'b1;
      tick();
      iRAS_en = 1'b0; iMUX_RZHS = 1'b0; iMUX_ASS = 1'b1; iRWB_en = 1'b1;
      tick();
      iMUX_ASS = 1'b0; iRWB_en = 1'b0; iRF_AddrC = 4'd2; iRF_Write = 1'b1;
      tick();
      iRF_Write = 1'b0; iRF_AddrB = 4'd2; #1;
      checks++;
      if (oMemData !== 32'hFFFFFFFF) $display("FAIL ras_wb: got %h required %h", oMemData, 32'hFFFFFFFF);
      else passes++;

      load_reg(4'd1, 32'd7);
      load_ra(4'd1);
      load_rb_imm(32'd2);
      exec(4'd10);
      checks++;
      if (oMemAddr !== 32'd3) $display("FAIL div_quot: got %h required %h", oMemAddr, 32'd3);
      else passes++;
      iMUX_RZHS = 1'b1; #1;
      checks++;
      if (oMemAddr !== 32'd1) $display("FAIL div_rem: got %h required %h", oMemAddr, 32'd1);
      else passes++;
      iMUX_RZHS = 1'b0;
      load_rb_imm(32'd0);
      exec(4'd10);
      checks++;
      if (oMemAddr !== 32'hFFFFFFFF) $display("FAIL div0_lo: got %h required %h", oMemAddr, 32'hFFFFFFFF);
      else passes++;
      iMUX_RZHS = 1'b1; #1;
      checks++;
      if (oMemAddr !== 32'd7) $display("FAIL div0_hi: got %h required %h", oMemAddr, 32'd7);
      else passes++;
      iMUX_RZHS = 1'b0;
      load_reg(4'd1, 32'hFFFFFFF9);
      load_ra(4'd1);
      load_rb_imm(32'd2);
      exec(4'd10);
      checks++;
      if (oMemAddr !== 32'hFFFFFFFD) $display("FAIL sdiv_quot: got %h required %h", oMemAddr, 32'hFFFFFFFD);
      else passes++;
      iMUX_RZHS = 1'b1; #1;
      checks++;
      if (oMemAddr !== 32'hFFFFFFFF) $display("FAIL sdiv_rem: got %h required %h", oMemAddr, 32'hFFFFFFFF);
      else passes++;
      iMUX_RZHS = 1'b0;
   endtask

   task automatic test_alu_table();
      op_t  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd1, 4'd11, 4'd12, 4'd15};
      rb_t  = '{32'h10, 32'h0000FFFF, 32'h0F, 32'd4, 32'd4, 32'd4, 32'd8, 32'd36,
                32'hF1, 32'd5, 32'h0F0F0F0F, 32'h12345678};
      exp_t = '{32'h80000100, 32'h000000F0, 32'h800000FF, 32'h0800000F, 32'hF800000F,
                32'h00000F00, 32'hF0800000, 32'h00000F08, 32'h7FFFFFFF, 32'hFFFFFFFB,
                32'hF0F0F0F0, 32'h12345678};
      load_reg(4'd1, 32'h800000F0);
      load_ra(4'd1);
      for (int i = 0; i < 12; i++) begin
         load_rb_imm(rb_t[i]);
         exec(op_t[i]);
         iMUX_RZHS = 1'b0; #1;
         checks++;
         if (oMemAddr !== exp_t[i]) $display("FAIL alu_op%0d_lo: got %h required %h", op_t[i], oMemAddr, exp_t[i]);
         else passes++;
         iMUX_RZHS = 1'b1; #1;
         checks++;
         if (oMemAddr !== 32'h0) $display("FAIL alu_op%0d_hi: got %h required %h", op_t[i], oMemAddr, 32'h0);
         else passes++;
         iMUX_RZHS = 1'b0;
      end
      load_rb_imm(32'h80000000);
      exec(4'd0);
      checks++;
      if (oMemAddr !== 32'h000000F0) $display("FAIL add_wrap: got %h required %h", oMemAddr, 32'h000000F0);
      else passes++;
   endtask

   task automatic test_back_to_back();
      iALU_Ctrl = 4'd13; iMUX_BIS = 1'b1; iImm32 = 32'h55;
      iRB_en = 1'b1; iRZL_en = 1'b1; iRWB_en = 1'b1;
      tick();
      iMUX_BIS = 1'b0; iRB_en = 1'b0; iRZL_en = 1'b0; iRWB_en = 1'b0;
      checks++;
      if (oMemAddr !== 32'h80000000) $display("FAIL b2b_rzl_old_rb: got %h required %h", oMemAddr, 32'h80000000);
      else passes++;
      iRF_AddrC = 4'd8; iRF_Write = 1'b1;
      tick();
      iRF_Write = 1'b0; iRF_AddrB = 4'd8; #1;
      checks++;
      if (oMemData !== 32'h000000F0) $display("FAIL b2b_rwb_old_res: got %h required %h", oMemData, 32'h000000F0);
      else passes++;
      exec(4'd13);
      checks++;
      if (oMemAddr !== 32'h55) $display("FAIL b2b_new_rb: got %h required %h", oMemAddr, 32'h55);
      else passes++;
   endtask

   task automatic test_branch_pc();
      load_ra(4'd0);
      checks++;
      if ({oJ_zero, oJ_nZero, oJ_pos, oJ_neg} !== 4'b1010) $display("FAIL jflags_zero: got %b required 1010", {oJ_zero, oJ_nZero, oJ_pos, oJ_neg});
      else passes++;
      load_ra(4'd4);
      checks++;
      if ({oJ_zero, oJ_nZero, oJ_pos, oJ_neg} !== 4'b0101) $display("FAIL jflags_neg: got %b required 0101", {oJ_zero, oJ_nZero, oJ_pos, oJ_neg});
      else passes++;
      iMUX_MAP = 1'b1; iPC_en = 1'b1;
      repeat (4) tick();
      checks++;
      if (oMemAddr !== 32'd5) $display("FAIL pc_count: got %h required %h", oMemAddr, 32'd5);
      else passes++;
      iPC_en = 1'b0; iPC_jmp = 1'b1; iPC_loadImm = 1'b1; iImm32 = 32'hFFFFFFFE;
      tick();
      checks++;
      if (oMemAddr !== 32'd5) $display("FAIL pc_hold: got %h required %h", oMemAddr, 32'd5);
      else passes++;
      iPC_en = 1'b1;
      tick();
      checks++;
      if (oMemAddr !== 32'd3) $display("FAIL pc_imm_jump: got %h required %h", oMemAddr, 32'd3);
      else passes++;
      iPC_jmp = 1'b0;
      tick();
      iPC_en = 1'b0; iPC_loadImm = 1'b0;
      checks++;
      if (oMemAddr !== 32'd4) $display("FAIL pc_no_jmp: got %h required %h", oMemAddr, 32'd4);
      else passes++;
      load_reg(4'd9, 32'h40);
      load_ra(4'd9);
      iPC_en = 1'b1; iPC_jmp = 1'b1; iPC_loadRA = 1'b1; iPC_loadImm = 1'b1;
      tick();
      iPC_en = 1'b0; iPC_jmp = 1'b0; iPC_loadRA = 1'b0; iPC_loadImm = 1'b0;
      checks++;
      if (oMemAddr !== 32'h40) $display("FAIL pc_ra_jump: got %h required %h", oMemAddr, 32'h40);
      else passes++;
      iMUX_WBP = 1'b1; iMUX_ASS = 1'b1; iRWB_en = 1'b1;
      tick();
      iMUX_WBP = 1'b0; iMUX_ASS = 1'b0; iRWB_en = 1'b0; iRF_AddrC = 4'd10; iRF_Write = 1'b1;
      tick();
      iRF_Write = 1'b0; iRF_AddrB = 4'd10; #1;
      checks++;
      if (oMemData !== 32'h40) $display("FAIL wb_pc: got %h required %h", oMemData, 32'h40);
      else passes++;
      iMemData = 32'h99; iMUX_WBM = 1'b1; iMUX_WBP = 1'b1; iRWB_en = 1'b1;
      tick();
      iMUX_WBM = 1'b0; iMUX_WBP = 1'b0; iRWB_en = 1'b0; iRF_AddrC = 4'd11; iRF_Write = 1'b1;
      tick();
      iRF_Write = 1'b0; iRF_AddrB = 4'd11; #1;
      checks++;
      if (oMemData !== 32'h99) $display("FAIL wb_mem_priority: got %h required %h", oMemData, 32'h99);
      else passes++;
      iPC_nRst = 1'b0; iPC_en = 1'b1; iPC_jmp = 1'b1; iPC_loadRA = 1'b1;
      tick();
      iPC_nRst = 1'b1; iPC_en = 1'b0; iPC_jmp = 1'b0; iPC_loadRA = 1'b0;
      checks++;
      if (oMemAddr !== 32'h0) $display("FAIL pc_sync_clear: got %h required %h", oMemAddr, 32'h0);
      else passes++;
   endtask

   task automatic test_reset_midrun();
      iMUX_MAP = 1'b1; iPC_en = 1'b1;
      repeat (2) tick();
      iPC_en = 1'b0;
      @(posedge iClk);
      #3 nRst = 1'b0;
      #1;
      checks++;
      if (oMemAddr !== 32'h0) $display("FAIL rst_pc: got %h required %h", oMemAddr, 32'h0);
      else passes++;
      iMUX_MAP = 1'b0; #1;
      checks++;
      if (oMemAddr !== 32'h0) $display("FAIL rst_rzl: got %h required %h", oMemAddr, 32'h0);
      else passes++;
      iRF_AddrB = 4'd4; #1;
      checks++;
      if (oMemData !== 32'h0 || oJ_zero !== 1'b1) $display("FAIL rst_rf_ra: R4=%h jzero=%b required 0/1", oMemData, oJ_zero);
      else passes++;
      nRst = 1'b1;
      iRF_AddrC = 4'd6; iRF_Write = 1'b1;
      tick();
      iRF_Write = 1'b0; iRF_AddrB = 4'd6; #1;
      checks++;
      if (oMemData !== 32'h0) $display("FAIL rst_rwb: got %h required %h", oMemData, 32'h0);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_regload();
      test_sub();
      test_mul_div();
      test_alu_table();
      test_back_to_back();
      test_branch_pc();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/minisrc_datapath.md
Name: minisrc_datapath

Overview:
- 32-bit register-transfer datapath of the MiniSRC processor.
- Contains a program counter, a 16x32 register file, ALU operand registers RA/RB, 64-bit result registers RZH/RZL, an ALU storage register RAS, a write-back register RWB, and the memory address/data outputs.
- All sequencing comes from the external control unit through enables and mux selects. The instruction register and decode are outside this block.

Parameters:
- None. All widths are fixed: 32-bit data, 4-bit register addresses, 4-bit ALU control.

Ports:
- iClk  in  1  clock; all state updates on the rising edge
- nRst  in  1  asynchronous active-low reset
- iMemData  in  32  memory read data
- oMemAddr  out  32  memory address
- oMemData  out  32  memory write data
- iPC_nRst  in  1  synchronous active-low PC clear
- iPC_en  in  1  PC update enable
- iPC_jmp  in  1  PC jump qualifier
- iPC_loadRA  in  1  jump target = RA
- iPC_loadImm  in  1  jump target = PC + iImm32
- iRF_Write  in  1  register file write enable (port C)
- iRF_AddrA / iRF_AddrB / iRF_AddrC  in  4 each  read A, read B, write C addresses
- iRWB_en  in  1  RWB load enable
- iALU_Ctrl  in  4  ALU operation
- iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en  in  1 each  register load enables
- oJ_zero, oJ_nZero, oJ_pos, oJ_neg  out  1 each  branch condition flags
- oALU_neg, oALU_zero  out  1 each  combinational ALU flags
- iMUX_BIS  in  1  RB source: 1 = iImm32, 0 = RF port B
- iMUX_RZHS  in  1  result select: 1 = RZH, 0 = RZL
- iMUX_WBM  in  1  write-back source = iMemData
- iMUX_WBP  in  1  write-back source = PC
- iMUX_MAP  in  1  oMemAddr source: 1 = PC
- iMUX_ASS  in  1  write-back source = RAS
- iImm32  in  32  sign-extended immediate from control

Behaviour:
- Reset: nRst low clears PC, all 16 registers, RA, RB, RZH, RZL, RAS and RWB to 0 immediately. With all mux selects 0, every output is 0.
- Register file:
  - Ports A and B are combinational reads.
  - Port C writes RWB at the clock edge when iRF_Write=1.
  - All 16 registers are general purpose, including R0.
  - A same-cycle read of the register being written returns the old value.
- RA <= RF[A] when iRA_en. RB <= (iMUX_BIS ? iImm32 : RF[B]) when iRB_en.
- ALU is combinational on RA and RB, producing a 64-bit result {hi, lo}. Encoding of iALU_Ctrl:
  - 0 ADD, 1 SUB (RA-RB), 2 AND, 3 OR
  - 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL; shift/rotate amount is RB[4:0]
  - 9 MUL: signed 64-bit product {hi, lo}
  - 10 DIV: signed; lo = quotient, hi = remainder; divide by zero gives lo = 0xFFFFFFFF, hi = RA
  - 11 NEG (-RB), 12 NOT (~RB)
  - 13-15 pass RB
  - hi = 0 for all operations except MUL and DIV. Arithmetic wraps modulo 2^32.
- RZH <= hi when iRZH_en. RZL <= lo when iRZL_en.
- Flags: oALU_zero = (lo==0), oALU_neg = lo[31], both combinational.
- Result select RES = iMUX_RZHS ? RZH : RZL. RAS <= RES when iRAS_en.
- Write-back mux, priority order: iMUX_WBM -> iMemData; else iMUX_WBP -> PC; else iMUX_ASS -> RAS; else RES. RWB <= mux output when iRWB_en.
- oMemAddr = iMUX_MAP ? PC : RES. oMemData = RF[B] (combinational).
- Branch flags, from RA:
  - oJ_zero = (RA==0); oJ_nZero = !oJ_zero
  - oJ_neg = RA[31]; oJ_pos = !RA[31]
- PC, evaluated at each clock edge in priority order:
  - iPC_nRst=0 -> PC=0
  - else iPC_en=0 -> hold
  - else iPC_jmp & iPC_loadRA -> PC=RA
  - else iPC_jmp & iPC_loadImm -> PC=PC+iImm32
  - else PC=PC+1 (word addressed)
- Latency: one edge from any enable to the register update. An ALU operation takes three edges to reach the register file: RZ, then RWB, then RF.
- Simultaneous enables update independently in the same edge, each from pre-edge values.
- Reset mid-operation aborts immediately. No partial state survives.

Test Plan:
- Reset: assert nRst=0 mid-run -> PC, RA, RZL, RWB and oMemAddr read 0 asynchronously, before the next edge.
- Register load: iMemData=0x22, WBM=1, RWB_en -> edge; then AddrC=3, RF_Write -> edge -> R3=0x22. Repeat with 0x24 into R7 and 0x28 into R4.
- SUB:
  - PC_nRst=1, MAP=1, PC_en=1, PC_jmp=1 -> oMemAddr=0 during the fetch cycle, PC=1 after the edge.
  - Then A=3, B=7, RA_en/RB_en; Ctrl=SUB, RZH_en/RZL_en; RWB_en; AddrC=4, RF_Write.
  - Required: R4=0xFFFFFFFE, oALU_neg=1, RZH=0.
- Immediate/MUL: BIS=1, iImm32=-3, RA=5, MUL -> RZL=0xFFFFFFF1, RZH=0xFFFFFFFF. RZHS=1 with RAS_en -> RAS=0xFFFFFFFF.
- DIV: RA=7, RB=2 -> RZL=3, RZH=1. RB=0 -> RZL=0xFFFFFFFF, RZH=7.
- Branch/PC:
  - RA=0 -> oJ_zero=1, oJ_pos=1.
  - PC=5, jmp+loadImm, iImm32=-2 -> PC=3.
  - jmp+loadRA with RA=0x40 -> PC=0x40.
  - WBP=1, RWB_en -> RWB=0x40.
